// File: rtl/gf_alu_pkg.sv
// Shared encodings, state type and sizing helpers for the bit-serial GF ALU sequencer.
package gf_alu_pkg;

    localparam logic [1:0] OP_XOR   = 2'b00;
    localparam logic [1:0] OP_AND   = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int ALU_LAT_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FIN
    } seq_state_t;

    // The period timer has to represent every value from 0 up to lat inclusive.
    function automatic int timer_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

    function automatic int index_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/gf_alu_bit_timer.sv
// Bit-index and bit-period counters for the serial sequencer; flags the slice sample cycle.
module gf_alu_bit_timer
    import gf_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = ALU_LAT_DEFAULT,
    localparam int IW     = index_width(WIDTH)
) (
    input  logic          gclk,
    input  logic          rst,
    input  logic          clear,
    input  logic          issue,
    input  logic          waiting,
    output logic [IW-1:0] bit_idx,
    output logic          sample_now,
    output logic          last_bit
);

    localparam int            TW       = timer_width(ALU_LAT);
    localparam logic [TW-1:0] LAT_VAL  = TW'(ALU_LAT);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    logic [TW-1:0] timer;

    assign sample_now = waiting && (timer == LAT_VAL);
    assign last_bit   = (bit_idx == LAST_IDX);

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge gclk) begin
        if (rst || clear) begin
            bit_idx <= '0;
            timer   <= '0;
        end else if (issue) begin
            timer <= TW'(1);
        end else if (sample_now) begin
            timer <= '0;
            if (!last_bit) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end else if (waiting) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/gf_alu_serial_seq.sv
// Bit-serial sequencer: feeds a 1-bit GF ALU slice LSB first, chains carries, reassembles the result.
module gf_alu_serial_seq
    import gf_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [1:0]       op_sel,
    input  logic             cmpl_x,
    input  logic             cmpl_y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             alu_x,
    output logic             alu_y,
    output logic             alu_carry_in,
    output logic             alu_end,
    output logic             alu_cmpl_x,
    output logic             alu_cmpl_y,
    output logic             alu_op_xor,
    output logic             alu_op_and,
    output logic             alu_op_arith,
    input  logic             alu_sum,
    input  logic             alu_carry_out,
    input  logic             alu_overflow,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             done,
    output logic             err
);

    localparam int IW = index_width(WIDTH);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [1:0]       op_q;
    logic             cmpl_x_q;
    logic             cmpl_y_q;
    logic             cin_q;
    logic             carry_q;
    logic             bad_op;
    logic             accept;
    logic             reject;
    logic             issuing;
    logic             waiting;
    logic [IW-1:0]    bit_idx;
    logic             sample_now;
    logic             last_bit;

    assign bad_op  = (op_sel == OP_RSVD);
    assign ready   = (state == ST_IDLE);
    assign accept  = ready && start && !bad_op;
    assign reject  = ready && start && bad_op;
    assign issuing = (state == ST_ISSUE);
    assign waiting = (state == ST_WAIT);
    assign done    = (state == ST_FIN);

    gf_alu_bit_timer #(
        .WIDTH   (WIDTH),
        .ALU_LAT (ALU_LAT)
    ) u_timer (
        .gclk       (gclk),
        .rst        (rst),
        .clear      (accept),
        .issue      (issuing),
        .waiting    (waiting),
        .bit_idx    (bit_idx),
        .sample_now (sample_now),
        .last_bit   (last_bit)
    );

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (accept) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (sample_now) state_next = last_bit ? ST_FIN : ST_ISSUE;
            ST_FIN:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            state     <= ST_IDLE;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            carry_q   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            err   <= reject;
            if (accept) begin
                result    <= '0;
                carry_out <= 1'b0;
                overflow  <= 1'b0;
                carry_q   <= 1'b0;
            end else if (sample_now) begin
                // Slice outputs are trusted only on this cycle; in-flight values are dropped.
                result[bit_idx] <= alu_sum;
                carry_q         <= alu_carry_out;
                if (last_bit) begin
                    carry_out <= alu_carry_out;
                    overflow  <= alu_overflow;
                end
            end
        end
    end

    // NOTE: operand holding registers are left unreset; they are only observed after an accept loads them.
    always_ff @(posedge gclk) begin
        if (accept) begin
            x_q      <= a;
            y_q      <= b;
            op_q     <= op_sel;
            cmpl_x_q <= cmpl_x;
            cmpl_y_q <= cmpl_y;
            cin_q    <= cin;
        end
    end

    // Slice inputs are pulse-style: valid only in the ISSUE cycle, zero otherwise.
    always_comb begin
        alu_x        = 1'b0;
        alu_y        = 1'b0;
        alu_carry_in = 1'b0;
        alu_end      = 1'b0;
        alu_cmpl_x   = 1'b0;
        alu_cmpl_y   = 1'b0;
        alu_op_xor   = 1'b0;
        alu_op_and   = 1'b0;
        alu_op_arith = 1'b0;
        if (issuing) begin
            alu_x        = x_q[bit_idx];
            alu_y        = y_q[bit_idx];
            alu_carry_in = (bit_idx == '0) ? cin_q : carry_q;
            alu_end      = last_bit;
            alu_cmpl_x   = cmpl_x_q;
            alu_cmpl_y   = cmpl_y_q;
            alu_op_xor   = (op_q == OP_XOR);
            alu_op_and   = (op_q == OP_AND);
            alu_op_arith = (op_q == OP_ARITH);
        end
    end

endmodule
